// File: rtl/regfile_rename.sv
// Register file with rename scoreboard: per-register value, busy bit and owning ROB tag.
// Define REGFILE_BYPASS_EN to forward a same-cycle commit to the read ports.
module regfile_rename #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int TAG_W  = 4
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic              rdy_in,
    input  logic              iss_en,
    input  logic [ADDR_W-1:0] iss_rd,
    input  logic [TAG_W-1:0]  iss_tag,
    input  logic              cmt_en,
    input  logic [ADDR_W-1:0] cmt_rd,
    input  logic [TAG_W-1:0]  cmt_tag,
    input  logic [DATA_W-1:0] cmt_data,
    input  logic              flush,
    input  logic [ADDR_W-1:0] raddr1,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2,
    output logic              rbusy1,
    output logic              rbusy2,
    output logic [TAG_W-1:0]  rtag1,
    output logic [TAG_W-1:0]  rtag2
);

    localparam int NREG = 2 ** ADDR_W;

    logic commit_go;
    logic issue_go;
    logic flush_go;

    assign commit_go = rdy_in && cmt_en && (cmt_rd != '0);
    assign issue_go  = rdy_in && iss_en && (iss_rd != '0) && !flush;
    assign flush_go  = rdy_in && flush;

    logic [DATA_W-1:0] value_arr [NREG];
    logic              busy_arr  [NREG];
    logic [TAG_W-1:0]  tag_arr   [NREG];

    genvar gi;
    generate
        for (gi = 0; gi < NREG; gi++) begin : g_reg
            if (gi == 0) begin : g_zero
                assign value_arr[gi] = '0;
                assign busy_arr[gi]  = 1'b0;
                assign tag_arr[gi]   = '0;
            end else begin : g_live
                logic [DATA_W-1:0] value_reg;
                logic              busy_reg;
                logic [TAG_W-1:0]  tag_reg;
                logic              cmt_hit;
                logic              iss_hit;

                assign cmt_hit = commit_go && (cmt_rd == ADDR_W'(gi));
                assign iss_hit = issue_go && (iss_rd == ADDR_W'(gi));

                // Flush beats issue, issue beats the commit's ownership release.
                always_ff @(posedge clk_in or negedge rst_n_in) begin
                    if (!rst_n_in) begin
                        value_reg <= '0;
                        busy_reg  <= 1'b0;
                        tag_reg   <= '0;
                    end else begin
                        if (cmt_hit) begin
                            value_reg <= cmt_data;
                        end
                        if (flush_go) begin
                            busy_reg <= 1'b0;
                            tag_reg  <= '0;
                        end else if (iss_hit) begin
                            busy_reg <= 1'b1;
                            tag_reg  <= iss_tag;
                        end else if (cmt_hit && busy_reg && (tag_reg == cmt_tag)) begin
                            busy_reg <= 1'b0;
                            tag_reg  <= '0;
                        end
                    end
                end

                assign value_arr[gi] = value_reg;
                assign busy_arr[gi]  = busy_reg;
                assign tag_arr[gi]   = tag_reg;
            end
        end
    endgenerate

    logic [ADDR_W-1:0] raddr_arr [2];
    logic [DATA_W-1:0] rdata_arr [2];
    logic              rbusy_arr [2];
    logic [TAG_W-1:0]  rtag_arr  [2];

    assign raddr_arr[0] = raddr1;
    assign raddr_arr[1] = raddr2;

    generate
        for (gi = 0; gi < 2; gi++) begin : g_rd
            logic [DATA_W-1:0] rd_data;
            logic              rd_busy;
            logic [TAG_W-1:0]  rd_tag;

            always_comb begin
                rd_data = value_arr[raddr_arr[gi]];
                rd_busy = busy_arr[raddr_arr[gi]];
                rd_tag  = tag_arr[raddr_arr[gi]];
`ifdef REGFILE_BYPASS_EN
                // Show the post-commit view; a same-cycle issue is deliberately not forwarded.
                if (commit_go && (cmt_rd == raddr_arr[gi])) begin
                    rd_data = cmt_data;
                    if (rd_busy && (rd_tag == cmt_tag)) begin
                        rd_busy = 1'b0;
                        rd_tag  = '0;
                    end
                end
`endif
                if (!rd_busy) begin
                    rd_tag = '0;
                end
            end

            assign rdata_arr[gi] = rd_data;
            assign rbusy_arr[gi] = rd_busy;
            assign rtag_arr[gi]  = rd_tag;
        end
    endgenerate

    assign rdata1 = rdata_arr[0];
    assign rdata2 = rdata_arr[1];
    assign rbusy1 = rbusy_arr[0];
    assign rbusy2 = rbusy_arr[1];
    assign rtag1  = rtag_arr[0];
    assign rtag2  = rtag_arr[1];

endmodule

// File: tb/tb_regfile_rename.sv
// Directed bench for regfile_rename: reset, issue/commit ownership, flush, reg 0, stall, bypass.
module tb_regfile_rename;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int TAG_W  = 4;

    logic              clk_in = 1'b0;
    logic              rst_n_in;
    logic              rdy_in;
    logic              iss_en;
    logic [ADDR_W-1:0] iss_rd;
    logic [TAG_W-1:0]  iss_tag;
    logic              cmt_en;
    logic [ADDR_W-1:0] cmt_rd;
    logic [TAG_W-1:0]  cmt_tag;
    logic [DATA_W-1:0] cmt_data;
    logic              flush;
    logic [ADDR_W-1:0] raddr1;
    logic [ADDR_W-1:0] raddr2;
    logic [DATA_W-1:0] rdata1;
    logic [DATA_W-1:0] rdata2;
    logic              rbusy1;
    logic              rbusy2;
    logic [TAG_W-1:0]  rtag1;
    logic [TAG_W-1:0]  rtag2;

    int vectors    = 0;
    int miscompares = 0;

    regfile_rename #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .TAG_W(TAG_W)) dut (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .rdy_in   (rdy_in),
        .iss_en   (iss_en),
        .iss_rd   (iss_rd),
        .iss_tag  (iss_tag),
        .cmt_en   (cmt_en),
        .cmt_rd   (cmt_rd),
        .cmt_tag  (cmt_tag),
        .cmt_data (cmt_data),
        .flush    (flush),
        .raddr1   (raddr1),
        .raddr2   (raddr2),
        .rdata1   (rdata1),
        .rdata2   (rdata2),
        .rbusy1   (rbusy1),
        .rbusy2   (rbusy2),
        .rtag1    (rtag1),
        .rtag2    (rtag2)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h required %0h", name, obs, exp);
        end
    endtask

    // Read one register on both ports and compare all three fields on each.
    task automatic rd(input string name, input logic [ADDR_W-1:0] a,
                      input logic [DATA_W-1:0] d, input logic b, input logic [TAG_W-1:0] t);
        raddr1 = a;
        raddr2 = a;
        #1;
        check({name, ".data1"}, 64'(rdata1), 64'(d));
        check({name, ".busy1"}, 64'(rbusy1), 64'(b));
        check({name, ".tag1"},  64'(rtag1),  64'(t));
        check({name, ".data2"}, 64'(rdata2), 64'(d));
        check({name, ".busy2"}, 64'(rbusy2), 64'(b));
        check({name, ".tag2"},  64'(rtag2),  64'(t));
        $display("read %-12s addr=%0d data=%h busy=%0d tag=%0d", name, a, rdata1, rbusy1, rtag1);
    endtask

    task automatic idle();
        iss_en = 1'b0; iss_rd = '0; iss_tag = '0;
        cmt_en = 1'b0; cmt_rd = '0; cmt_tag = '0; cmt_data = '0;
        flush  = 1'b0;
    endtask

    task automatic issue(input logic [ADDR_W-1:0] r, input logic [TAG_W-1:0] t);
        iss_en = 1'b1; iss_rd = r; iss_tag = t;
    endtask

    task automatic commit(input logic [ADDR_W-1:0] r, input logic [TAG_W-1:0] t,
                          input logic [DATA_W-1:0] d);
        cmt_en = 1'b1; cmt_rd = r; cmt_tag = t; cmt_data = d;
    endtask

    // Apply the driven inputs at one rising edge, then return to idle inputs.
    task automatic cyc();
        @(posedge clk_in);
        #1;
        idle();
    endtask

    initial begin
        idle();
        rdy_in   = 1'b1;
        rst_n_in = 1'b0;
        raddr1   = '0;
        raddr2   = '0;
        #12;
        for (int i = 0; i < 2 ** ADDR_W; i++) begin
            rd("reset", ADDR_W'(i), '0, 1'b0, '0);
        end
        @(negedge clk_in);
        rst_n_in = 1'b1;
        cyc();

        // Issue then commit with matching tag.
        issue(5, 3);
        cyc();
        rd("r5_issued", 5, 32'h0, 1'b1, 4'd3);
        commit(5, 3, 32'hDEADBEEF);
        cyc();
        rd("r5_commit", 5, 32'hDEADBEEF, 1'b0, 4'd0);

        // Re-issue before the older producer commits: stale commit keeps ownership.
        issue(7, 1);
        cyc();
        issue(7, 2);
        cyc();
        commit(7, 1, 32'h11);
        cyc();
        rd("r7_stale", 7, 32'h11, 1'b1, 4'd2);
        commit(7, 2, 32'h22);
        cyc();
        rd("r7_final", 7, 32'h22, 1'b0, 4'd0);

        // Same-cycle issue and commit to one register: issue owns, commit writes value.
        issue(8, 6);
        cyc();
        commit(8, 6, 32'h88);
        issue(8, 7);
        cyc();
        rd("r8_iss_cmt", 8, 32'h88, 1'b1, 4'd7);

        // Flush with same-cycle issue and commit.
        commit(4, 0, 32'h44);
        cyc();
        issue(3, 1);
        cyc();
        issue(4, 2);
        cyc();
        flush = 1'b1;
        issue(9, 5);
        commit(3, 9, 32'h55);
        cyc();
        rd("flush_r3", 3, 32'h55, 1'b0, 4'd0);
        rd("flush_r4", 4, 32'h44, 1'b0, 4'd0);
        rd("flush_r9", 9, 32'h0, 1'b0, 4'd0);
        cyc();
        rd("flush_r8", 8, 32'h88, 1'b0, 4'd0);

        // Register 0 is immutable.
        issue(0, 4'hF);
        commit(0, 4'hF, 32'hFFFF_FFFF);
        cyc();
        rd("r0_write", 0, 32'h0, 1'b0, 4'd0);

        // rdy_in low freezes issue, commit and flush.
        issue(11, 4);
        cyc();
        rdy_in = 1'b0;
        flush  = 1'b1;
        issue(10, 3);
        commit(5, 0, 32'h1234);
        cyc();
        rd("stall_r10", 10, 32'h0, 1'b0, 4'd0);
        rd("stall_r5", 5, 32'hDEADBEEF, 1'b0, 4'd0);
        rd("stall_r11", 11, 32'h0, 1'b1, 4'd4);
        rdy_in = 1'b1;
        cyc();

        // Same-cycle commit seen by readers only with bypass.
        commit(6, 0, 32'hABCD);
        raddr1 = 6;
        raddr2 = 6;
        #1;
`ifdef REGFILE_BYPASS_EN
        check("bypass_r6.data2", 64'(rdata2), 64'h0000ABCD);
`else
        check("bypass_r6.data2", 64'(rdata2), 64'h0);
`endif
        cyc();
        rd("r6_after", 6, 32'hABCD, 1'b0, 4'd0);

        issue(12, 2);
        cyc();
        commit(12, 2, 32'h77);
        raddr1 = 12;
        raddr2 = 12;
        #1;
`ifdef REGFILE_BYPASS_EN
        check("bypass_r12.busy1", 64'(rbusy1), 64'h0);
        check("bypass_r12.tag1",  64'(rtag1),  64'h0);
`else
        check("bypass_r12.busy1", 64'(rbusy1), 64'h1);
        check("bypass_r12.tag1",  64'(rtag1),  64'h2);
`endif
        cyc();
        rd("r12_after", 12, 32'h77, 1'b0, 4'd0);

        // Asynchronous reset between clock edges.
        rst_n_in = 1'b0;
        #1;
        rd("areset_r11", 11, 32'h0, 1'b0, 4'd0);
        rd("areset_r3", 3, 32'h0, 1'b0, 4'd0);
        @(negedge clk_in);
        rst_n_in = 1'b1;
        cyc();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/regfile_rename.md
REGFILE_RENAME -- requirements
Module: regfile_rename

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register data width in bits.
REQ-002 SHALL have parameter ADDR_W, default 5, register address width; register count NREG = 2**ADDR_W.
REQ-003 SHALL have parameter TAG_W, default 4, reorder-buffer tag width in bits.
REQ-004 SHALL have port clk_in  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n_in  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port rdy_in  input  1  global ready; low freezes all state.
REQ-007 SHALL have ports iss_en/iss_rd/iss_tag  input  1/ADDR_W/TAG_W  issue: mark iss_rd busy, owned by iss_tag.
REQ-008 SHALL have ports cmt_en/cmt_rd/cmt_tag/cmt_data  input  1/ADDR_W/TAG_W/DATA_W  commit: write value, release ownership.
REQ-009 SHALL have port flush  input  1  mispredict flush; clears all busy bits.
REQ-010 SHALL have ports raddr1/raddr2  input  ADDR_W  read addresses.
REQ-011 SHALL have ports rdata1/rdata2  output  DATA_W  read values.
REQ-012 SHALL have ports rbusy1/rbusy2  output  1  read register awaiting result.
REQ-013 SHALL have ports rtag1/rtag2  output  TAG_W  owning tag of read register; 0 when not busy.

Function
REQ-014 SHALL hold per register: value[DATA_W], busy, tag[TAG_W].
REQ-015 Register 0 SHALL never be written, never be busy; reads give data 0, busy 0, tag 0.
REQ-016 Commit (rdy_in & cmt_en & cmt_rd!=0) SHALL write value<=cmt_data unconditionally at the edge.
REQ-017 Commit SHALL clear busy and set tag to 0 only if busy==1 and tag==cmt_tag; otherwise busy/tag unchanged.
REQ-018 Issue (rdy_in & iss_en & iss_rd!=0 & !flush) SHALL set busy<=1, tag<=iss_tag at the edge.
REQ-019 Issue and commit to same register in one cycle: value SHALL take cmt_data; busy=1, tag=iss_tag (issue wins).
REQ-020 flush & rdy_in SHALL clear every busy bit and tag at the edge, preserve all values, ignore same-cycle issue, and still perform same-cycle commit value write.
REQ-021 Reads SHALL be combinational from current state; state updates visible one cycle after the edge.
REQ-022 Issue SHALL never be forwarded to same-cycle reads.
REQ-023 rdy_in low SHALL block issue, commit, flush; reads remain valid.
REQ-024 rtag SHALL be 0 whenever rbusy is 0.

Reset
REQ-025 rst_n_in low SHALL immediately (asynchronously) clear all values, busy bits and tags to 0.
REQ-026 Reset SHALL override any issue, commit or flush in progress; first update after deassertion occurs on the next rising edge.

Configuration
REQ-027 Macro REGFILE_BYPASS_EN defined: a read matching a qualifying commit (REQ-016) SHALL return cmt_data, and busy/tag as post-commit (cleared if tag matches, else unchanged).
REQ-028 REGFILE_BYPASS_EN undefined: reads SHALL return pre-edge state only; no commit-to-read forwarding logic.

Verification
REQ-029 Reset then read all addresses -> data 0, busy 0, tag 0 everywhere.
REQ-030 Issue rd=5 tag=3; next cycle raddr1=5 -> rbusy1=1, rtag1=3; commit rd=5 tag=3 data=0xDEADBEEF; next cycle -> rdata1=0xDEADBEEF, rbusy1=0, rtag1=0.
REQ-031 Issue rd=7 tag=1, then issue rd=7 tag=2, commit rd=7 tag=1 data=0x11 -> value 0x11, rbusy=1, rtag=2; commit tag=2 data=0x22 -> value 0x22, busy 0.
REQ-032 Busy r3,r4; flush with same-cycle issue rd=9 tag=5 and commit rd=3 data=0x55 -> all busy 0 incl. r9, r3 value 0x55, r4 value preserved.
REQ-033 Issue/commit rd=0 data=0xFFFF_FFFF; and any op with rdy_in=0 -> reg 0 stays 0, no state change.
REQ-034 Commit rd=6 data=0xABCD with raddr2=6 same cycle -> rdata2=0xABCD with REGFILE_BYPASS_EN, old value without; 0xABCD next cycle in both builds.
